// File: rtl/pb_arbiter_pkg.sv
// Shared definitions for the pushbutton command arbiter: FSM encoding,
// default sizing and the acknowledge-counter width rule.
package pb_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  localparam int N_REQ_DEF    = 4;
  localparam int ACK_WAIT_DEF = 15;
  localparam int CNT_W_DEF    = $clog2(ACK_WAIT_DEF + 1);

  // Width needed to hold ACK_WAIT; never below one bit so a zero wait still elaborates.
  function automatic int cnt_width(input int ack_wait);
    return (ack_wait < 1) ? 1 : $clog2(ack_wait + 1);
  endfunction

endpackage

// File: rtl/pb_arbiter_rr_pick.sv
// Round-robin picker: first pending index at or after PTR, wrapping to 0.
module rr_pick
  import pb_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] PEND,
  input  logic [IDX_W-1:0] PTR,
  output logic [IDX_W-1:0] GNT_IDX,
  output logic             GNT_ANY
);

  // Scan from the farthest offset down so the nearest pending index wins last.
  always_comb begin
    int j;
    j       = 0;
    GNT_IDX = '0;
    GNT_ANY = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(PTR) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (PEND[IDX_W'(j)]) begin
        GNT_IDX = IDX_W'(j);
        GNT_ANY = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pb_arbiter.sv
// Arbitrates one-shot pushbutton requests onto a single downstream unit,
// issuing one command at a time and waiting for its BUSY handshake.
module pb_arbiter
  import pb_arbiter_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int ACK_WAIT = ACK_WAIT_DEF
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic [N_REQ-1:0]         ENOS,
  input  logic                     BUSY,
  output logic                     CMD_VALID,
  output logic [$clog2(N_REQ)-1:0] CMD_ID,
  output logic [N_REQ-1:0]         PEND,
  output logic                     DROP,
  output logic                     TMO
);

  localparam int               IDX_W    = $clog2(N_REQ);
  localparam int               CNT_W    = cnt_width(ACK_WAIT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACK_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  state_e           state_q;
  logic [N_REQ-1:0] pend_q;
  logic [N_REQ-1:0] pend_d;
  logic [N_REQ-1:0] clr_mask;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W-1:0] cmd_id_q;
  logic [IDX_W-1:0] gnt_idx;
  logic [CNT_W-1:0] cnt_q;
  logic             cmd_valid_q;
  logic             drop_q;
  logic             drop_d;
  logic             tmo_q;
  logic             gnt_any;
  logic             grant;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .PEND    (pend_q),
    .PTR     (ptr_q),
    .GNT_IDX (gnt_idx),
    .GNT_ANY (gnt_any)
  );

  // A fresh request on the index being granted re-arms it instead of dropping.
  always_comb begin
    grant    = (state_q == ST_IDLE) && gnt_any && !BUSY;
    clr_mask = '0;
    if (grant) clr_mask[gnt_idx] = 1'b1;
    pend_d = (pend_q & ~clr_mask) | ENOS;
    drop_d = |(ENOS & pend_q & ~clr_mask);
    ptr_d  = (gnt_idx == IDX_LAST) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q     <= ST_IDLE;
      pend_q      <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_id_q    <= '0;
      drop_q      <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      drop_q      <= drop_d;
      cmd_valid_q <= 1'b0;
      tmo_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant) begin
            state_q     <= ST_ISSUE;
            cmd_valid_q <= 1'b1;
            cmd_id_q    <= gnt_idx;
            ptr_q       <= ptr_d;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT_ACK;
          cnt_q   <= CNT_LOAD;
        end
        // The edge that takes the counter to zero is the one that reports the timeout.
        ST_WAIT_ACK: begin
          if (BUSY) begin
            state_q <= ST_WAIT_DONE;
          end else if (cnt_q <= CNT_ONE) begin
            cnt_q   <= '0;
            tmo_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!BUSY) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign CMD_VALID = cmd_valid_q;
  assign CMD_ID    = cmd_id_q;
  assign PEND      = pend_q;
  assign DROP      = drop_q;
  assign TMO       = tmo_q;

endmodule

// File: tb/tb_pb_arbiter.sv
// Bench for pb_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a timestamp-based model.
module tb_pb_arbiter;

  localparam int N  = 4;
  localparam int AW = 15;

  logic         CLK = 1'b0;
  logic         RSTn;
  logic         BUSY;
  logic [N-1:0] ENOS;
  logic         CMD_VALID;
  logic [1:0]   CMD_ID;
  logic [N-1:0] PEND;
  logic         DROP;
  logic         TMO;

  int tests_run    = 0;
  int tests_failed = 0;
  bit chk_en       = 1'b0;

  // Behavioural model state
  logic [N-1:0] m_pend   = '0;
  int           m_ptr    = 0;
  bit           m_idle   = 1'b1;
  bit           m_engaged = 1'b0;
  int           mcyc     = 0;
  int           win_lo   = 0;
  int           deadline = 0;
  bit           exp_valid = 1'b0;
  bit           exp_drop  = 1'b0;
  bit           exp_tmo   = 1'b0;
  int           exp_id    = 0;

  pb_arbiter #(
    .N_REQ    (N),
    .ACK_WAIT (AW)
  ) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .ENOS      (ENOS),
    .BUSY      (BUSY),
    .CMD_VALID (CMD_VALID),
    .CMD_ID    (CMD_ID),
    .PEND      (PEND),
    .DROP      (DROP),
    .TMO       (TMO)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input int act, input int want);
    tests_run++;
    if (act != want) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Model: a grant at edge g opens an acknowledge window on edges g+2..g+1+AW;
  // BUSY inside it engages the unit until BUSY drops, otherwise the last edge times out.
  initial begin
    int clr;
    forever begin
      @(posedge CLK);
      mcyc++;
      if (!RSTn) begin
        m_pend = '0; m_ptr = 0; m_idle = 1'b1; m_engaged = 1'b0;
        exp_valid = 1'b0; exp_id = 0; exp_drop = 1'b0; exp_tmo = 1'b0;
      end else begin
        clr = -1;
        exp_valid = 1'b0; exp_tmo = 1'b0; exp_drop = 1'b0;
        if (m_idle) begin
          if (m_pend != '0 && !BUSY) begin
            for (int k = 0; k < N; k++)
              if (clr < 0 && m_pend[(m_ptr + k) % N]) clr = (m_ptr + k) % N;
            exp_valid = 1'b1;
            exp_id    = clr;
            m_ptr     = (clr + 1) % N;
            m_idle    = 1'b0;
            m_engaged = 1'b0;
            win_lo    = mcyc + 2;
            deadline  = mcyc + 1 + AW;
          end
        end else if (m_engaged) begin
          if (!BUSY) begin m_idle = 1'b1; m_engaged = 1'b0; end
        end else if (mcyc >= win_lo) begin
          if (BUSY) m_engaged = 1'b1;
          else if (mcyc == deadline) begin exp_tmo = 1'b1; m_idle = 1'b1; end
        end
        for (int i = 0; i < N; i++) begin
          if (ENOS[i] && m_pend[i] && i != clr) exp_drop = 1'b1;
          if (ENOS[i]) m_pend[i] = 1'b1;
          else if (i == clr) m_pend[i] = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (chk_en) begin
        chk("cmp_valid", int'(CMD_VALID), int'(exp_valid));
        chk("cmp_id",    int'(CMD_ID),    exp_id);
        chk("cmp_pend",  int'(PEND),      int'(m_pend));
        chk("cmp_drop",  int'(DROP),      int'(exp_drop));
        chk("cmp_tmo",   int'(TMO),       int'(exp_tmo));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic settle();
    repeat (4) @(negedge CLK);
  endtask

  task automatic pulse(input logic [N-1:0] v);
    @(negedge CLK);
    ENOS = v;
    @(negedge CLK);
    ENOS = '0;
  endtask

  task automatic ack(input int dly, input int hold);
    repeat (dly) @(negedge CLK);
    BUSY = 1'b1;
    repeat (hold) @(negedge CLK);
    BUSY = 1'b0;
  endtask

  task automatic wait_valid(input string nm, input int want_id, input int budget);
    int lat;
    lat = -1;
    for (int k = 1; k <= budget && lat < 0; k++) begin
      @(negedge CLK);
      if (CMD_VALID) lat = k;
    end
    chk({nm, "_seen"}, int'(lat > 0), 1);
    if (lat > 0) chk({nm, "_id"}, int'(CMD_ID), want_id);
  endtask

  initial begin
    int tmo_at;
    int nval;
    int on_at;
    int off_at;
    RSTn = 1'b0; ENOS = '0; BUSY = 1'b0;

    @(negedge CLK);
    chk_en = 1'b1;
    step();
    chk("rst_valid", int'(CMD_VALID), 0);
    chk("rst_id",    int'(CMD_ID),    0);
    chk("rst_pend",  int'(PEND),      0);
    chk("rst_drop",  int'(DROP),      0);
    chk("rst_tmo",   int'(TMO),       0);
    RSTn = 1'b1;
    step();

    // Round-robin over all four from PTR=0
    pulse(4'b1111);
    chk("rr_pend_all", int'(PEND), 15);
    for (int i = 0; i < 4; i++) begin
      wait_valid("rr", i, 30);
      ack(2, 2);
    end
    settle();
    pulse(4'b1001);
    wait_valid("rr_ptr0_first", 0, 5);
    ack(2, 2);
    wait_valid("rr_ptr0_second", 3, 30);
    ack(2, 2);
    settle();

    // Single request, 2-cycle latency, pointer advances past the winner
    pulse(4'b0100);
    chk("single_pend_set", int'(PEND), 4);
    chk("single_valid_early", int'(CMD_VALID), 0);
    step();
    chk("single_valid", int'(CMD_VALID), 1);
    chk("single_id", int'(CMD_ID), 2);
    chk("single_pend_clr", int'(PEND), 0);
    ack(3, 5);
    settle();
    pulse(4'b1001);
    step();
    chk("single_next_valid", int'(CMD_VALID), 1);
    chk("single_next_id", int'(CMD_ID), 3);
    ack(2, 2);
    wait_valid("single_wrap", 0, 30);
    ack(2, 2);
    settle();

    // Collapse while BUSY holds the arbiter idle
    BUSY = 1'b1;
    step();
    pulse(4'b0010);
    chk("collapse_pend1", int'(PEND), 2);
    chk("collapse_nodrop", int'(DROP), 0);
    pulse(4'b0010);
    chk("collapse_drop", int'(DROP), 1);
    chk("collapse_pend2", int'(PEND), 2);
    step();
    chk("collapse_drop_end", int'(DROP), 0);
    repeat (3) step();
    chk("collapse_held", int'(CMD_VALID), 0);
    BUSY = 1'b0;
    wait_valid("collapse_grant", 1, 5);
    ack(2, 2);
    nval = 0;
    repeat (10) begin step(); if (CMD_VALID) nval++; end
    chk("collapse_single", nval, 0);
    chk("collapse_pend_final", int'(PEND), 0);

    // Acknowledge timeout, then the remaining request is served
    pulse(4'b0011);
    step();
    chk("tmo_grant_valid", int'(CMD_VALID), 1);
    chk("tmo_grant_id", int'(CMD_ID), 0);
    tmo_at = -1;
    for (int k = 1; k <= AW + 5 && tmo_at < 0; k++) begin
      step();
      if (TMO) tmo_at = k;
    end
    chk("tmo_latency", tmo_at, 16);
    step();
    chk("tmo_pulse_end", int'(TMO), 0);
    chk("tmo_next_valid", int'(CMD_VALID), 1);
    chk("tmo_next_id", int'(CMD_ID), 1);
    ack(2, 2);
    settle();

    // Same-cycle request and grant clear on index 0
    BUSY = 1'b1;
    pulse(4'b0001);
    chk("setclr_pend_pre", int'(PEND), 1);
    step();
    BUSY = 1'b0;
    ENOS = 4'b0001;
    step();
    ENOS = '0;
    chk("setclr_valid", int'(CMD_VALID), 1);
    chk("setclr_id", int'(CMD_ID), 0);
    chk("setclr_pend", int'(PEND), 1);
    chk("setclr_nodrop", int'(DROP), 0);
    ack(2, 2);
    wait_valid("setclr_second", 0, 8);
    ack(2, 2);
    settle();
    chk("setclr_pend_final", int'(PEND), 0);

    // Reset during WAIT_DONE with requests pending
    pulse(4'b0100);
    step();
    chk("rstmid_id", int'(CMD_ID), 2);
    step();
    BUSY = 1'b1;
    repeat (2) step();
    pulse(4'b1010);
    chk("rstmid_pend", int'(PEND), 10);
    step();
    RSTn = 1'b0;
    ENOS = 4'b0001;
    step();
    RSTn = 1'b1;
    ENOS = '0;
    BUSY = 1'b0;
    chk("rstmid_valid", int'(CMD_VALID), 0);
    chk("rstmid_cmdid", int'(CMD_ID), 0);
    chk("rstmid_pend0", int'(PEND), 0);
    chk("rstmid_drop", int'(DROP), 0);
    chk("rstmid_tmo", int'(TMO), 0);
    nval = 0;
    repeat (8) begin step(); if (CMD_VALID) nval++; end
    chk("rstmid_quiet", nval, 0);
    pulse(4'b0001);
    chk("rstmid_valid_early", int'(CMD_VALID), 0);
    step();
    chk("rstmid_post_valid", int'(CMD_VALID), 1);
    chk("rstmid_post_id", int'(CMD_ID), 0);
    ack(2, 2);
    settle();

    // Randomized traffic with a reactive downstream unit
    on_at = -100;
    off_at = -100;
    for (int n = 0; n < 3000; n++) begin
      @(negedge CLK);
      if (CMD_VALID) begin
        on_at  = n + int'($urandom_range(1, AW + 4));
        off_at = on_at + int'($urandom_range(1, 6));
      end
      BUSY = ((n >= on_at) && (n < off_at)) || ($urandom_range(0, 199) == 0);
      ENOS = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      RSTn = ($urandom_range(0, 399) != 0);
    end
    RSTn = 1'b1;
    ENOS = '0;
    BUSY = 1'b0;
    repeat (40) step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pb_arbiter.md
PB_ARBITER -- requirements
Module: pb_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 The block SHALL have parameter ACK_WAIT, default 15, max cycles from CMD_VALID to BUSY rise.
REQ-003 The block SHALL have port CLK, input, 1, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port RSTn, input, 1, synchronous active-low reset.
REQ-005 The block SHALL have port ENOS, input, N_REQ, one-cycle request pulses, one per pushbutton one-shot.
REQ-006 The block SHALL have port BUSY, input, 1, downstream unit busy; its rise is the acknowledge.
REQ-007 The block SHALL have port CMD_VALID, output, 1, one-cycle command strobe.
REQ-008 The block SHALL have port CMD_ID, output, clog2(N_REQ), index of the granted requester; valid with CMD_VALID.
REQ-009 The block SHALL have port PEND, output, N_REQ, pending-request flags.
REQ-010 The block SHALL have port DROP, output, 1, one-cycle pulse when a request collapses into an existing pending one.
REQ-011 The block SHALL have port TMO, output, 1, one-cycle pulse on acknowledge timeout.

Function
REQ-012 ENOS[i]=1 SHALL set PEND[i] on the next edge.
REQ-013 Each grant SHALL clear the winner's PEND bit on the edge where CMD_VALID is asserted.
REQ-014 ENOS[i] in the same cycle as PEND[i] is cleared by a grant SHALL leave PEND[i]=1 (new request wins over the clear); no DROP.
REQ-015 ENOS[i] while PEND[i]=1 and not being cleared SHALL pulse DROP for one cycle, leaving PEND[i]=1.
REQ-016 Winner SHALL be chosen round-robin: first PEND bit at or after pointer PTR, wrapping from N_REQ-1 to 0.
REQ-017 After a grant to index k, PTR SHALL become (k+1) mod N_REQ; PTR SHALL be 0 after reset.
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT_ACK and WAIT_DONE.
REQ-019 In IDLE, when PEND!=0 and BUSY=0, the FSM SHALL go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-020 ISSUE SHALL last exactly one cycle with CMD_VALID=1 and CMD_ID=winner, then go to WAIT_ACK.
REQ-021 Latency from an ENOS pulse to CMD_VALID, with the block idle and BUSY=0, SHALL be 2 cycles.
REQ-022 WAIT_ACK SHALL load a down-counter with ACK_WAIT.
REQ-023 In WAIT_ACK, BUSY=1 SHALL move the FSM to WAIT_DONE.
REQ-024 In WAIT_ACK, if the counter reaches 0 with BUSY=0, the FSM SHALL pulse TMO and return to IDLE; the dropped command is not re-queued.
REQ-025 In WAIT_DONE, BUSY=0 SHALL return the FSM to IDLE; BUSY has no timeout here.
REQ-026 CMD_ID SHALL hold its last value outside ISSUE.
REQ-027 CMD_VALID SHALL never assert on two consecutive cycles.
REQ-028 PEND capture SHALL continue in every state.
REQ-029 The winner SHALL be evaluated in IDLE, using PEND and PTR as registered.

Reset
REQ-030 With RSTn=0 at a rising CLK edge, the block SHALL go to state IDLE, with PEND=0, PTR=0, counter=0, CMD_VALID=0, CMD_ID=0, DROP=0 and TMO=0.
REQ-031 Reset SHALL override everything, including mid-ISSUE or mid-WAIT; ENOS pulses in reset cycles are discarded.
REQ-032 The first grant SHALL be possible 2 cycles after RSTn returns high.

Structure
REQ-033 A shared package SHALL hold the state encoding (2-bit, IDLE=0), the default N_REQ and ACK_WAIT, and the counter width clog2(ACK_WAIT+1).
REQ-034 The round-robin picker SHALL be a separate combinational sub-module rr_pick.
REQ-035 rr_pick SHALL take inputs PEND and PTR and produce outputs GNT_IDX and GNT_ANY.
REQ-036 All other logic SHALL reside in pb_arbiter.
REQ-037 ENOS SHALL come from existing one-shot instances; the block SHALL NOT synchronise ENOS itself.

Verification
REQ-038 Single request: pulse ENOS=0100; BUSY goes high 3 cycles after CMD_VALID and is held 5 cycles -> CMD_VALID at +2 with CMD_ID=2; PEND back to 0000; next grant from PTR=3.
REQ-039 Round-robin: ENOS=1111 in one cycle, BUSY acked each command -> CMD_ID sequence 0,1,2,3; PTR ends at 0.
REQ-040 Collapse: ENOS[1] pulsed twice while BUSY=1 holds the FSM in IDLE -> one DROP pulse, PEND=0010, and a single grant with CMD_ID=1 after BUSY falls.
REQ-041 Timeout: grant issued, BUSY held 0 -> TMO pulse ACK_WAIT+1 cycles after CMD_VALID (16 cycles at the default); FSM in IDLE; next pending request is served.
REQ-042 Simultaneous set/clear: ENOS[0] in the ISSUE cycle granting index 0 -> PEND[0]=1 afterwards, no DROP, second grant with CMD_ID=0.
REQ-043 Reset mid-operation: RSTn=0 for 1 cycle during WAIT_DONE with PEND=1010 -> all outputs 0, PEND=0000; no CMD_VALID until a new ENOS pulse.
